// File: rtl/ofs_fim_pcie_ss_rxcrdt_sched.sv
// Multi-segment RX credit accumulator: sums per-segment buffer releases into six
// cumulative credit counters and streams changed counters round-robin over rxcrdt.
module ofs_fim_pcie_ss_rxcrdt_sched #(
    parameter int NUM_SEG        = 1,
    parameter int P_HDR_INIT     = 128,
    parameter int NP_HDR_INIT    = 128,
    parameter int CPL_HDR_INIT   = 256,
    parameter int P_DATA_INIT    = 768,
    parameter int NP_DATA_INIT   = 256,
    parameter int CPL_DATA_INIT  = 1024,
    parameter int REFRESH_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SEG-1:0]    rel_valid,
    input  logic [2*NUM_SEG-1:0]  rel_type,
    input  logic [NUM_SEG-1:0]    rel_has_data,
    input  logic [10*NUM_SEG-1:0] rel_len,
    output logic                  rxcrdt_tvalid,
    input  logic                  rxcrdt_tready,
    output logic [18:0]           rxcrdt_tdata
);

    // Counter slots are kept by round-robin position 0..5 = PH, NPH, CPLH, PD, NPD, CPLD.
    localparam logic [15:0] CNT_INIT [6] = '{
        16'(P_HDR_INIT), 16'(NP_HDR_INIT), 16'(CPL_HDR_INIT),
        16'(P_DATA_INIT), 16'(NP_DATA_INIT), 16'(CPL_DATA_INIT)
    };
    localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int REFRESH_LAST_I = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;
    localparam logic [TW-1:0] REFRESH_LAST = TW'(REFRESH_LAST_I);

    function automatic logic [10:0] seg_credits(input logic [9:0] len);
        logic [10:0] len_dw;
        len_dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
        return (len_dw + 11'd3) >> 2;
    endfunction

    function automatic logic [2:0] rr_pos(input logic [2:0] ptr, input int off);
        return 3'((int'(ptr) + off) % 6);
    endfunction

    function automatic logic [2:0] pos_to_idx(input logic [2:0] pos);
        return (pos >= 3'd3) ? {1'b1, 2'(pos - 3'd3)} : {1'b0, pos[1:0]};
    endfunction

    logic [2:0]    hsum_d [3];
    logic [2:0]    hsum_q [3];
    logic [10:0]   dsum_d [3];
    logic [10:0]   dsum_q [3];
    logic [15:0]   cnt_d  [6];
    logic [15:0]   cnt_q  [6];
    logic [5:0]    changed;
    logic [5:0]    dirty_d, dirty_q;
    logic [2:0]    ptr_d, ptr_q;
    logic          tvalid_d, tvalid_q;
    logic [18:0]   tdata_d, tdata_q;
    logic [TW-1:0] timer_d, timer_q;
    logic          init_q;
    logic          refresh_hit;
    logic          set_all;
    logic          load;
    logic          pick_found;
    logic [2:0]    pick_pos;

    // NOTE: every always_comb output is assigned a default before any branch so no latch is inferred.
    always_comb begin : stage1_comb
        for (int t = 0; t < 3; t++) begin
            hsum_d[t] = '0;
            dsum_d[t] = '0;
            for (int s = 0; s < NUM_SEG; s++) begin
                if (rel_valid[s] && (rel_type[2*s +: 2] == 2'(t))) begin
                    hsum_d[t] = hsum_d[t] + 3'd1;
                    if (rel_has_data[s]) begin
                        dsum_d[t] = dsum_d[t] + seg_credits(rel_len[10*s +: 10]);
                    end
                end
            end
        end
    end

    always_comb begin : counter_comb
        for (int t = 0; t < 3; t++) begin
            cnt_d[t]       = cnt_q[t] + {13'd0, hsum_q[t]};
            cnt_d[t+3]     = cnt_q[t+3] + {5'd0, dsum_q[t]};
            changed[t]     = (hsum_q[t] != 3'd0);
            changed[t+3]   = (dsum_q[t] != 11'd0);
        end
    end

    // The timer restarts on every set-all event, including the one at reset release.
    assign refresh_hit = (REFRESH_CYCLES != 0) && (timer_q == REFRESH_LAST);
    assign set_all     = init_q || refresh_hit;
    assign timer_d     = set_all ? '0 : timer_q + TW'(1);

    always_comb begin : sched_comb
        pick_found = 1'b0;
        pick_pos   = ptr_q;
        for (int off = 1; off <= 6; off++) begin
            if (!pick_found && dirty_q[rr_pos(ptr_q, off)]) begin
                pick_found = 1'b1;
                pick_pos   = rr_pos(ptr_q, off);
            end
        end

        load     = !tvalid_q || rxcrdt_tready;
        dirty_d  = dirty_q;
        ptr_d    = ptr_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        if (load) begin
            tvalid_d = pick_found;
            if (pick_found) begin
                tdata_d           = {pos_to_idx(pick_pos), cnt_q[pick_pos]};
                ptr_d             = pick_pos;
                dirty_d[pick_pos] = 1'b0;
            end
        end
        // Sets are applied after the load clear so a same-cycle set wins.
        dirty_d = dirty_d | changed | {6{set_all}};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < 3; t++) begin
                hsum_q[t] <= '0;
                dsum_q[t] <= '0;
            end
            for (int p = 0; p < 6; p++) begin
                cnt_q[p] <= CNT_INIT[p];
            end
            dirty_q  <= '0;
            ptr_q    <= 3'd5;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            timer_q  <= '0;
            init_q   <= 1'b1;
        end else begin
            hsum_q   <= hsum_d;
            dsum_q   <= dsum_d;
            cnt_q    <= cnt_d;
            dirty_q  <= dirty_d;
            ptr_q    <= ptr_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            timer_q  <= timer_d;
            init_q   <= 1'b0;
        end
    end

    assign rxcrdt_tvalid = tvalid_q;
    assign rxcrdt_tdata  = tdata_q;

endmodule
